// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and register-file write sequencer.
// Splits 64-bit results aimed at a general register pair into two writes.
module wb_stage #(
  parameter logic [4:0] ACC_REG = 5'd31
) (
  input  logic        clk,
  input  logic        res,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        acc_in,
  input  logic [4:0]  reg_dst_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_data_in,
  input  logic [63:0] acc_result_in,
  output logic        regwrite,
  output logic        acc,
  output logic [4:0]  write_reg_num,
  output logic [31:0] write_data,
  output logic [63:0] write_data_acc,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic        pair_err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PAIR_HI
  } state_t;

  state_t      state;
  logic [4:0]  hi_reg;
  logic [31:0] hi_data;

  logic        accept;
  logic        is_zero;
  logic        is_acc;
  logic        is_wide;
  logic        is_pair;
  logic        is_top;
  logic [31:0] sel_data;

  assign ready_out = (state != PAIR_HI);
  assign accept    = valid_in && ready_out;

  assign is_zero  = (reg_dst_in == 5'd0);
  assign is_acc   = acc_in && (reg_dst_in == ACC_REG);
  assign is_wide  = acc_in && regwrite_in && !is_zero && !is_acc;
  // Only r1..r29 have a partner register; r30 gets the low half alone.
  assign is_pair  = is_wide && (reg_dst_in < 5'd30);
  assign is_top   = is_wide && !is_pair;
  assign sel_data = memtoreg_in ? mem_data_in : alu_result_in;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state          <= IDLE;
      regwrite       <= 1'b0;
      acc            <= 1'b0;
      write_reg_num  <= 5'd0;
      write_data     <= 32'd0;
      write_data_acc <= 64'd0;
      pair_err       <= 1'b0;
      hi_reg         <= 5'd0;
      hi_data        <= 32'd0;
    end else begin
      unique case (1'b1)
        (state == PAIR_HI): begin
          regwrite      <= 1'b1;
          acc           <= 1'b0;
          write_reg_num <= hi_reg;
          write_data    <= hi_data;
          state         <= WRITE;
        end
        accept: begin
          regwrite      <= regwrite_in && !is_zero;
          acc           <= is_acc;
          write_reg_num <= reg_dst_in;
          if (is_acc) begin
            write_data_acc <= acc_result_in;
          end else if (acc_in) begin
            write_data <= acc_result_in[31:0];
          end else begin
            write_data <= sel_data;
          end
          hi_reg   <= reg_dst_in + 5'd1;
          hi_data  <= acc_result_in[63:32];
          pair_err <= pair_err | is_top;
          state    <= is_pair ? PAIR_HI : WRITE;
        end
        default: begin
          regwrite <= 1'b0;
          acc      <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign fwd_valid = regwrite;
  assign fwd_reg   = acc ? ACC_REG : write_reg_num;
  assign fwd_data  = acc ? write_data_acc[31:0] : write_data;

endmodule
